// File: rtl/nmr_bstrm_pkg.sv
// Shared command-word layout and loader state encoding for the NMR bitstream SRAM loader.
package nmr_bstrm_pkg;

   localparam int CMD_EOS      = 127;
   localparam int CMD_LSTA     = 126;
   localparam int CMD_LSTO     = 125;
   localparam int CMD_PAT      = 124;
   localparam int CMD_ONES     = 123;
   localparam int CMD_ZEROS    = 122;
   localparam int CMD_RSVD_HI  = 121;
   localparam int CMD_RSVD_LO  = 120;
   localparam int CMD_DATA_HI  = 119;

   typedef struct packed {
      logic       eos;
      logic       loop_sta;
      logic       loop_sto;
      logic       pattern_mode;
      logic       all_1s;
      logic       all_0s;
      logic [1:0] rsvd;
   } cmd_hdr_t;

   typedef struct packed {
      cmd_hdr_t                 hdr;
      logic [CMD_DATA_HI:0]     data;
   } cmd_word_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_WRITE,
      ST_LOADED,
      ST_LAUNCH,
      ST_RUN,
      ST_ERROR
   } ldr_state_t;

endpackage

// File: rtl/nmr_bstrm_cmd_check.sv
// Combinational legality check of one command-word header against the current loop nesting state.
module nmr_bstrm_cmd_check
   import nmr_bstrm_pkg::*;
(
   input  cmd_hdr_t hdr,
   input  logic     last,
   input  logic     loop_open,
   output logic     ok
);

   always_comb begin
      ok = 1'b1;
      if (hdr.rsvd != 2'b00) ok = 1'b0;
      if ((hdr.pattern_mode & hdr.all_1s) | (hdr.pattern_mode & hdr.all_0s) |
          (hdr.all_1s & hdr.all_0s)) ok = 1'b0;
      if (hdr.loop_sta && hdr.loop_sto) ok = 1'b0;
      if (hdr.loop_sto && !loop_open) ok = 1'b0;
      if (hdr.loop_sta && loop_open) ok = 1'b0;
      if (last != hdr.eos) ok = 1'b0;
      // a loop left open by the final word can never be closed
      if (last && (loop_open || hdr.loop_sta) && !hdr.loop_sto) ok = 1'b0;
   end

endmodule

// File: rtl/nmr_bstrm_sram_loader.sv
// Packs host beats into 128-bit command words, stores them in SRAM and launches the bitstream arbiter.
// Define BSTRM_LDR_CHECK_EN to reject illegal command words before they are written.
//
// state   | meaning
// IDLE    | no words pending, waiting for first beat
// COLLECT | gathering beats of the current word
// WRITE   | one-cycle SRAM write of the packed word
// LOADED  | program stored, waiting for go
// LAUNCH  | one-cycle start pulse to the arbiter
// RUN     | arbiter owns the SRAM, waiting for done
// ERROR   | terminal until reset
module nmr_bstrm_sram_loader
   import nmr_bstrm_pkg::*;
#(
   parameter int HOST_WIDTH        = 32,
   parameter int SRAM_ADDR_WIDTH   = 8,
   parameter int SRAM_DAT_WIDTH    = 128,
   parameter int SRAM_BYTEEN_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         host_valid,
   output logic                         host_ready,
   input  logic [HOST_WIDTH-1:0]        host_dat,
   input  logic                         host_last,
   input  logic                         go,
   output logic                         loaded,
   output logic                         busy,
   output logic                         err,
   output logic [SRAM_ADDR_WIDTH:0]     word_cnt,
   output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr,
   output logic                         sram_cs,
   output logic                         sram_clken,
   output logic                         sram_wr,
   output logic [SRAM_DAT_WIDTH-1:0]    sram_wr_dat,
   output logic [SRAM_BYTEEN_WIDTH-1:0] sram_byteen,
   output logic                         bstrm_start,
   input  logic                         bstrm_done
);

   localparam int BEATS = SRAM_DAT_WIDTH / HOST_WIDTH;
   localparam int BW    = $clog2(BEATS);
   localparam logic [BW-1:0]            LAST_BEAT = BW'(BEATS - 1);
   localparam logic [SRAM_ADDR_WIDTH:0] CNT_FULL  = {1'b1, {SRAM_ADDR_WIDTH{1'b0}}};

   ldr_state_t                  state, state_nxt;
   logic [BW-1:0]               beat_cnt;
   logic [SRAM_DAT_WIDTH-1:0]   word_buf;
   logic                        last_q;
   logic [SRAM_ADDR_WIDTH:0]    cnt_q;
   logic                        rdy_en;
   logic                        beat_fire;
   logic                        write_ok;
   logic                        check_ok;

   assign host_ready = rdy_en && (state == ST_IDLE || state == ST_COLLECT);
   assign beat_fire  = host_valid && host_ready;
   // the address counter is never allowed to wrap; a full SRAM turns the next write into an error
   assign write_ok   = (state == ST_WRITE) && (cnt_q != CNT_FULL) && check_ok;

`ifdef BSTRM_LDR_CHECK_EN
   logic     loop_open;
   cmd_hdr_t cur_hdr;

   assign cur_hdr = cmd_hdr_t'(word_buf[CMD_EOS:CMD_RSVD_LO]);

   nmr_bstrm_cmd_check u_cmd_check (
      .hdr       (cur_hdr),
      .last      (last_q),
      .loop_open (loop_open),
      .ok        (check_ok)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         loop_open <= 1'b0;
      else if (state_nxt == ST_IDLE && state != ST_IDLE)
         loop_open <= 1'b0;
      else if (write_ok)
         loop_open <= (loop_open | cur_hdr.loop_sta) & ~cur_hdr.loop_sto;
   end
`else
   assign check_ok = 1'b1;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_COLLECT: begin
            if (beat_fire) begin
               if (beat_cnt == LAST_BEAT) state_nxt = ST_WRITE;
               else if (host_last)        state_nxt = ST_ERROR;
               else                       state_nxt = ST_COLLECT;
            end
         end
         ST_WRITE: begin
            if (!write_ok)   state_nxt = ST_ERROR;
            else if (last_q) state_nxt = ST_LOADED;
            else             state_nxt = ST_COLLECT;
         end
         ST_LOADED: if (go) state_nxt = ST_LAUNCH;
         ST_LAUNCH: state_nxt = ST_RUN;
         ST_RUN:    if (bstrm_done) state_nxt = ST_IDLE;
         ST_ERROR:  state_nxt = ST_ERROR;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         beat_cnt <= '0;
         word_buf <= '0;
         last_q   <= 1'b0;
         cnt_q    <= '0;
         rdy_en   <= 1'b0;
      end else begin
         state  <= state_nxt;
         rdy_en <= 1'b1;
         if (beat_fire) begin
            word_buf <= {word_buf[SRAM_DAT_WIDTH-HOST_WIDTH-1:0], host_dat};
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            last_q   <= host_last;
         end
         if (write_ok)
            cnt_q <= cnt_q + 1'b1;
         else if (state == ST_RUN && bstrm_done)
            cnt_q <= '0;
      end
   end

   assign sram_cs     = write_ok;
   assign sram_clken  = write_ok;
   assign sram_wr     = write_ok;
   assign sram_addr   = write_ok ? cnt_q[SRAM_ADDR_WIDTH-1:0] : '0;
   assign sram_wr_dat = write_ok ? word_buf : '0;
   assign sram_byteen = {SRAM_BYTEEN_WIDTH{write_ok}};

   assign loaded      = (state == ST_LOADED);
   assign bstrm_start = (state == ST_LAUNCH);
   assign busy        = (state == ST_LAUNCH) || (state == ST_RUN);
   assign err         = (state == ST_ERROR);
   assign word_cnt    = cnt_q;

endmodule
